// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, defaults
// and the address legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned LATENCY_DEF    = 2;
  localparam int unsigned DEPTH_LOG2_DEF = 6;
  localparam int unsigned CNT_W          = 3;

  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
  localparam int unsigned WORD_SHIFT = 2;

  // Misaligned, or any address bit above the storage window set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned dlog2);
    return ((addr & ALIGN_MASK) != '0) || ((addr >> (dlog2 + WORD_SHIFT)) != '0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage for the responder: one write port, one asynchronous read
// port, all words cleared by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder: accepts one request at a time, waits
// LATENCY cycles, then issues a single-cycle response.
//
// state | meaning
// IDLE  | ready for a request; accept when req_valid
// WAIT  | request captured, down-counter running to terminal count 1
// RESP  | resp_valid/rdata/err presented for one cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY    = LATENCY_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [31:0]      resp_rdata_q;

  logic                  accept;
  logic                  to_resp;
  logic                  cur_we;
  logic                  cur_err;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [31:0]           rd_data;
  logic                  mem_we;

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign to_resp = (accept && (LATENCY == 0)) ||
                   ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

  // With zero latency the transaction resolves on the accept edge itself,
  // so the live request stands in for the not-yet-captured copy.
  assign cur_we    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign cur_err   = addr_err(cur_addr, DEPTH_LOG2);
  assign cur_idx   = cur_addr[DEPTH_LOG2+1:2];
  assign mem_we    = to_resp && cur_we && !cur_err;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (cur_idx),
    .wdata_i (cur_wdata),
    .raddr_i (cur_idx),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;

      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          cnt_q   <= '0;
        end
      endcase

      if (to_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= cur_err;
        resp_rdata_q <= (cur_we || cur_err) ? 32'h0 : rd_data;
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 0, 7)
// share clock and reset and are exercised one after another.
module tb_dmem_responder;

  logic clk;
  logic reset;

  int n_vec;
  int n_miss;

  dmem_responder_if if_l2 ();
  dmem_responder_if if_l0 ();
  dmem_responder_if if_l7 ();

  dmem_responder #(.LATENCY(2), .DEPTH_LOG2(6)) u_l2 (.clk(clk), .reset(reset), .bus(if_l2));
  dmem_responder #(.LATENCY(0), .DEPTH_LOG2(6)) u_l0 (.clk(clk), .reset(reset), .bus(if_l0));
  dmem_responder #(.LATENCY(7), .DEPTH_LOG2(6)) u_l7 (.clk(clk), .reset(reset), .bus(if_l7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    case (sel)
      0: begin if_l2.req_valid = v; if_l2.req_we = we; if_l2.req_addr = a; if_l2.req_wdata = d; end
      1: begin if_l0.req_valid = v; if_l0.req_we = we; if_l0.req_addr = a; if_l0.req_wdata = d; end
      default: begin if_l7.req_valid = v; if_l7.req_we = we; if_l7.req_addr = a; if_l7.req_wdata = d; end
    endcase
  endtask

  task automatic sample(input int sel, output logic rdy, output logic rv,
                        output logic err, output logic [31:0] rd);
    case (sel)
      0: begin rdy = if_l2.req_ready; rv = if_l2.resp_valid; err = if_l2.resp_err; rd = if_l2.resp_rdata; end
      1: begin rdy = if_l0.req_ready; rv = if_l0.resp_valid; err = if_l0.resp_err; rd = if_l0.resp_rdata; end
      default: begin rdy = if_l7.req_ready; rv = if_l7.resp_valid; err = if_l7.resp_err; rd = if_l7.resp_rdata; end
    endcase
  endtask

  // Called on a negedge with the target in IDLE. Returns on a negedge with
  // the target back in IDLE. Latency is counted in cycles after the accept
  // edge, so the response is expected in cycle lat+1. With noise set, a
  // toggling bogus store is presented while the request is outstanding.
  task automatic do_txn(input int sel, input string tag, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input bit noise,
                        output logic [31:0] rdata, output logic err);
    logic rdy, rv, e;
    logic [31:0] rd;
    int n;
    bit seen;
    sample(sel, rdy, rv, e, rd);
    chk({tag, "_ready"}, 32'(rdy), 32'd1);
    drive(sel, 1'b1, we, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    seen  = 1'b0;
    n     = 0;
    rdata = '0;
    err   = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      sample(sel, rdy, rv, e, rd);
      if (rv) begin
        seen  = 1'b1;
        n     = i;
        rdata = rd;
        err   = e;
      end else begin
        if (noise) drive(sel, i[0], 1'b1, addr, 32'hFFFF_FFFF);
        @(negedge clk);
      end
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, "_lat"}, 32'(n), 32'(lat + 1));
    @(negedge clk);
    sample(sel, rdy, rv, e, rd);
    chk({tag, "_pulse"}, 32'(rv), 32'd0);
  endtask

  logic        rdy, rv, e, rv_seen;
  logic [31:0] rd;
  logic [31:0] rdata;
  logic        err;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    sample(0, rdy, rv, e, rd);
    chk("rst_ready",  32'(rdy), 32'd1);
    chk("rst_rvalid", 32'(rv),  32'd0);
    chk("rst_err",    32'(e),   32'd0);
    chk("rst_rdata",  rd,       32'h0);
    reset = 1'b0;
    @(negedge clk);

    // LATENCY=2: store then load back
    do_txn(0, "l2_st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, rdata, err);
    chk("l2_st10_err", 32'(err), 32'd0);
    do_txn(0, "l2_ld10", 1'b0, 32'h10, 32'h0, 2, 1'b0, rdata, err);
    chk("l2_ld10_rdata", rdata, 32'hDEAD_BEEF);
    chk("l2_ld10_err",   32'(err), 32'd0);

    // Error cases: word 0 made nonzero so an aliased out-of-range read shows up
    do_txn(0, "l2_st00", 1'b1, 32'h0, 32'h0BAD_F00D, 2, 1'b0, rdata, err);
    do_txn(0, "l2_st13", 1'b1, 32'h13, 32'h1111_1111, 2, 1'b0, rdata, err);
    chk("l2_st13_err",   32'(err), 32'd1);
    chk("l2_st13_rdata", rdata, 32'h0);
    do_txn(0, "l2_ld100", 1'b0, 32'h100, 32'h0, 2, 1'b0, rdata, err);
    chk("l2_ld100_err",   32'(err), 32'd1);
    chk("l2_ld100_rdata", rdata, 32'h0);
    do_txn(0, "l2_ld11", 1'b0, 32'h11, 32'h0, 2, 1'b0, rdata, err);
    chk("l2_ld11_err",   32'(err), 32'd1);
    chk("l2_ld11_rdata", rdata, 32'h0);
    do_txn(0, "l2_rb10", 1'b0, 32'h10, 32'h0, 2, 1'b0, rdata, err);
    chk("l2_rb10_rdata", rdata, 32'hDEAD_BEEF);
    do_txn(0, "l2_rb00", 1'b0, 32'h0, 32'h0, 2, 1'b0, rdata, err);
    chk("l2_rb00_rdata", rdata, 32'h0BAD_F00D);

    // LATENCY=0: back-to-back loads with req_valid held
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    sample(1, rdy, rv, e, rd);
    chk("l0_b2b_rdy0", 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    sample(1, rdy, rv, e, rd);
    chk("l0_b2b_rdy1",  32'(rdy), 32'd0);
    chk("l0_b2b_rv1",   32'(rv),  32'd1);
    chk("l0_b2b_rd1",   rd,       32'h0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    sample(1, rdy, rv, e, rd);
    chk("l0_b2b_rdy2", 32'(rdy), 32'd1);
    chk("l0_b2b_rv2",  32'(rv),  32'd0);
    @(negedge clk);
    sample(1, rdy, rv, e, rd);
    chk("l0_b2b_rdy3", 32'(rdy), 32'd0);
    chk("l0_b2b_rv3",  32'(rv),  32'd1);
    chk("l0_b2b_rd3",  rd,       32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // LATENCY=0: store immediately followed by load of the same word
    do_txn(1, "l0_st08", 1'b1, 32'h8, 32'hCAFE_F00D, 0, 1'b0, rdata, err);
    do_txn(1, "l0_ld08", 1'b0, 32'h8, 32'h0, 0, 1'b0, rdata, err);
    chk("l0_ld08_rdata", rdata, 32'hCAFE_F00D);

    // Reset while a LATENCY=2 store is waiting
    drive(0, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample(0, rdy, rv, e, rd);
    chk("rstw_inwait_rdy", 32'(rdy), 32'd0);
    reset   = 1'b1;
    rv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sample(0, rdy, rv, e, rd);
      rv_seen = rv_seen | rv;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sample(0, rdy, rv, e, rd);
      rv_seen = rv_seen | rv;
    end
    chk("rstw_no_resp", 32'(rv_seen), 32'd0);
    chk("rstw_rdy",     32'(rdy),     32'd1);
    do_txn(0, "rstw_ld08", 1'b0, 32'h8, 32'h0, 2, 1'b0, rdata, err);
    chk("rstw_ld08_rdata", rdata, 32'h0);

    // LATENCY=7: noise on req_valid during WAIT must not be accepted
    do_txn(2, "l7_st20", 1'b1, 32'h20, 32'h7777_0001, 7, 1'b0, rdata, err);
    do_txn(2, "l7_ld20", 1'b0, 32'h20, 32'h0, 7, 1'b1, rdata, err);
    chk("l7_ld20_rdata", rdata, 32'h7777_0001);
    chk("l7_ld20_err",   32'(err), 32'd0);
    do_txn(2, "l7_rb20", 1'b0, 32'h20, 32'h0, 7, 1'b0, rdata, err);
    chk("l7_rb20_rdata", rdata, 32'h7777_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2, SHALL set the number of wait cycles between request acceptance and response (legal 0..7).
REQ-002 Parameter DEPTH_LOG2, default 6, SHALL set the storage depth to 2^DEPTH_LOG2 32-bit words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL indicate that the pipeline MEM stage is presenting a load or store request.
REQ-006 req_ready  output  1  SHALL indicate that the responder can accept a request this cycle.
REQ-007 req_we  input  1  SHALL select store (1) or load (0).
REQ-008 req_addr  input  32  SHALL carry the byte address; the word index is req_addr[DEPTH_LOG2+1:2].
REQ-009 req_wdata  input  32  SHALL carry the store data.
REQ-010 resp_valid  output  1  SHALL pulse high for exactly one cycle per accepted request.
REQ-011 resp_rdata  output  32  SHALL carry load data while resp_valid is high, and 0 otherwise.
REQ-012 resp_err  output  1  SHALL flag a misaligned or out-of-range request while resp_valid is high, and 0 otherwise.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-014 Acceptance SHALL occur on the edge where state=IDLE and req_valid=1; the responder captures req_we, req_addr and req_wdata on that edge.
REQ-015 On acceptance, the FSM SHALL go to RESP if LATENCY=0; otherwise it goes to WAIT with the counter loaded to LATENCY.
REQ-016 In WAIT, the counter SHALL decrement each edge; the FSM leaves for RESP on the edge where the counter equals 1.
REQ-017 resp_valid SHALL be high in RESP only, so it rises exactly LATENCY+1 cycles after the accept edge.
REQ-018 From RESP the FSM SHALL return to IDLE unconditionally; one outstanding request maximum; throughput one request per LATENCY+2 cycles.
REQ-019 Error condition: req_addr[1:0]!=0 or req_addr[31:DEPTH_LOG2+2]!=0; it SHALL be evaluated on captured values.
REQ-020 A store without error SHALL commit to storage on the edge entering RESP; a store with error SHALL leave storage unchanged.
REQ-021 A load without error SHALL drive the word stored at the captured index onto resp_rdata in RESP; a load with error SHALL drive resp_rdata=0.
REQ-022 Request inputs SHALL be ignored while not in IDLE; a held req_valid is re-accepted only on returning to IDLE.
REQ-023 A load to the address of the immediately preceding store SHALL return the newly stored data (the store is committed before the next acceptance).
REQ-024 Counter width SHALL be 3 bits; the counter SHALL never wrap during a transaction.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after release, and clear all storage words to 0.
REQ-026 Reset asserted during WAIT or RESP SHALL abort the transaction; a pending store SHALL be discarded and no response SHALL be issued.

Structure
REQ-027 The shared package dmem_pkg SHALL hold the state encoding (IDLE, WAIT, RESP), the default LATENCY and DEPTH_LOG2 values, and the error-check helper constants.
REQ-028 Storage SHALL be a sub-module dmem_array (one write port, one read port, asynchronous clear); the FSM and counter SHALL reside in dmem_responder.

Verification
REQ-029 With LATENCY=2: store 0xDEADBEEF at 0x10, accepted at edge 0. Required: resp_valid at cycle 3 with err=0. Then load 0x10. Required: rdata=0xDEADBEEF, err=0.
REQ-030 With LATENCY=0: back-to-back loads of 0x0 and 0x4 with req_valid held. Required: req_ready toggles 1,0,1; each resp_valid lands one cycle after its accept; rdata=0 after reset.
REQ-031 Misaligned store at 0x13 and out-of-range load at 0x100 (DEPTH_LOG2=6). Required: err=1 on both, rdata=0, and word 4 is unchanged when read back.
REQ-032 Reset asserted in WAIT for a store of 0x12345678 at 0x8. Required: no resp_valid; req_ready=1 after release; a later load of 0x8 returns 0.
REQ-033 With LATENCY=7: a single load. Required: resp_valid exactly 8 cycles after accept; req_valid toggled during WAIT is ignored.
